// File: rtl/bcd_pkg.sv
// Shared constants for the BCD sum display: active-high segment codes and
// the one-hot anode/digit-select encoding.
package bcd_pkg;

  // Segment bit order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high anode pattern; bit 0 = units, bit 1 = tens.
  typedef enum logic [1:0] {
    DIG_NONE  = 2'b00,
    DIG_UNITS = 2'b01,
    DIG_TENS  = 2'b10
  } digit_t;

endpackage

// File: rtl/bcd_sum_display_bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder; non-BCD
// nibbles decode to a dash.
module bcd_to_7seg
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sum_display.sv
// Latches the BCD adder result and scans it onto a 2-digit multiplexed
// 7-segment display with guard blanking, leading-zero blanking and "Er" blink.
module bcd_sum_display
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 4,
  parameter int BLINK_DIV  = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic       error,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] SEG_INV = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_INV  = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [3:0]    d0;
  logic [3:0]    d1;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          dsel;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic          wrap;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_n;
  digit_t        an_n;

  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  bcd_to_7seg u_dec (
    .digit (dsel ? d1 : d0),
    .seg   (dec_seg)
  );

  // Next display pattern, built only from registered state so the pins
  // see it one clock later and never glitch.
  always_comb begin
    seg_n = SEG_BLANK;
    an_n  = DIG_NONE;
    if (cnt >= CW'(GUARD)) begin
      if (err_q) begin
        if (blink_on) begin
          seg_n = dsel ? SEG_E : SEG_R;
          an_n  = dsel ? DIG_TENS : DIG_UNITS;
        end
      end else if (!dsel) begin
        seg_n = dec_seg;
        an_n  = DIG_UNITS;
      end else if (d1 != 4'd0) begin
        seg_n = dec_seg;
        an_n  = DIG_TENS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0        <= '0;
      d1        <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      dsel      <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      seg       <= SEG_BLANK ^ SEG_INV;
      an        <= 2'(DIG_NONE) ^ AN_INV;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) dsel <= ~dsel;

      if (load) begin
        d0    <= s0;
        d1    <= s1;
        err_q <= error;
      end

      // A clean capture restarts the blink so leaving error is immediate;
      // the counter only advances at frame ends (tens-to-units wrap).
      if (load && !error) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (err_q && wrap && dsel) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      seg <= seg_n ^ SEG_INV;
      an  <= 2'(an_n) ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_bcd_sum_display.sv
// Scoreboard bench for bcd_sum_display: one active-low and one active-high
// instance share stimulus; expectations are active-low {seg, an} per edge.
module tb_bcd_sum_display;

  localparam int SCAN = 8;
  localparam int GRD  = 2;
  localparam int BLK  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] s0 = 4'd0;
  logic [3:0] s1 = 4'd0;
  logic       error = 1'b0;
  logic [6:0] seg_lo, seg_hi;
  logic [1:0] an_lo, an_hi;

  logic [8:0] exp_q[$];
  logic [8:0] e;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic [6:0] seg_tab [16];
  int         pos = 0;
  logic [3:0] m_s0 = 4'd0;
  logic [3:0] m_s1 = 4'd0;
  logic       m_err = 1'b0;
  int         bl = 0;

  // clock / reset
  always #5 clk = ~clk;

  bcd_sum_display #(.SCAN_DIV(SCAN), .GUARD(GRD), .BLINK_DIV(BLK), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .load(load), .s0(s0), .s1(s1), .error(error),
    .seg(seg_lo), .an(an_lo)
  );

  bcd_sum_display #(.SCAN_DIV(SCAN), .GUARD(GRD), .BLINK_DIV(BLK), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .load(load), .s0(s0), .s1(s1), .error(error),
    .seg(seg_hi), .an(an_hi)
  );

  // Expected active-low output for the coming edge, from the scan position
  // and the data captured so far.
  function automatic logic [8:0] expect_now();
    logic [6:0] sh;
    logic [1:0] ah;
    int cnt;
    int tens;
    bit on;
    sh   = 7'h00;
    ah   = 2'b00;
    cnt  = pos % SCAN;
    tens = pos / SCAN;
    on   = ((bl / BLK) % 2) == 0;
    if (cnt >= GRD) begin
      if (m_err) begin
        if (on) begin
          sh = (tens == 1) ? 7'h79 : 7'h50;
          ah = (tens == 1) ? 2'b10 : 2'b01;
        end
      end else if (tens == 0) begin
        sh = seg_tab[m_s0];
        ah = 2'b01;
      end else if (m_s1 != 4'd0) begin
        sh = seg_tab[m_s1];
        ah = 2'b10;
      end
    end
    return {~sh, ~ah};
  endfunction

  // driver
  task automatic step(input logic r, input logic ld, input logic [3:0] a1,
                      input logic [3:0] a0, input logic er);
    @(negedge clk);
    rst = r; load = ld; s1 = a1; s0 = a0; error = er;
    if (r) exp_q.push_back(9'h1FF);
    else   exp_q.push_back(expect_now());
    if (r) begin
      pos = 0; m_s0 = 4'd0; m_s1 = 4'd0; m_err = 1'b0; bl = 0;
    end else begin
      if (pos == 2 * SCAN - 1 && m_err) bl++;
      if (ld) begin
        m_s0 = a0; m_s1 = a1; m_err = er;
        if (!er) bl = 0;
      end
      pos = (pos + 1) % (2 * SCAN);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({seg_lo, an_lo} !== e) begin
        n_fail++;
        $display("FAIL low_pol t=%0t got seg=%h an=%b want seg=%h an=%b",
                 $time, seg_lo, an_lo, e[8:2], e[1:0]);
      end
      n_tests++;
      if ({seg_hi, an_hi} !== ~e) begin
        n_fail++;
        $display("FAIL high_pol t=%0t got seg=%h an=%b want seg=%h an=%b",
                 $time, seg_hi, an_hi, ~e[8:2], ~e[1:0]);
      end
      if (an_lo == 2'b00) begin
        n_tests++;
        n_fail++;
        $display("FAIL two_anodes t=%0t got an=%b want at most one low", $time, an_lo);
      end
    end
  end

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;

    // reset for three cycles, then a frame of the cleared "0"
    repeat (3) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    idle(16);

    // 17, then 5 with tens blanked
    step(1'b0, 1'b1, 4'd1, 4'd7, 1'b0);
    idle(32);
    step(1'b0, 1'b1, 4'd0, 4'd5, 1'b0);
    idle(32);

    // continuous recapture, including non-BCD nibbles shown as dashes
    step(1'b0, 1'b1, 4'hC, 4'hA, 1'b0);
    step(1'b0, 1'b1, 4'd2, 4'd3, 1'b0);
    step(1'b0, 1'b1, 4'hC, 4'hA, 1'b0);
    idle(16);

    // error entered at a frame boundary; a repeated error capture mid-run
    while (pos != 2 * SCAN - 1) idle(1);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b1);
    idle(20);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b1);
    idle(79);

    // clear during a dark frame: 9 shows on the next visible units cycle
    step(1'b0, 1'b1, 4'd0, 4'd9, 1'b0);
    idle(16);

    // reset in the middle of the tens slot with load asserted
    step(1'b0, 1'b1, 4'd4, 4'd2, 1'b0);
    while (pos != SCAN + 2) idle(1);
    step(1'b1, 1'b1, 4'd3, 4'd3, 1'b1);
    step(1'b1, 1'b1, 4'd3, 4'd3, 1'b1);
    idle(16);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
